// File: rtl/mips_cache_pkg.sv
// Shared types, default geometry and address-slicing helpers for the
// direct-mapped MIPS instruction cache.
package mips_cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int DEF_NUM_LINES      = 8;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Geometry helpers so a parameterised instance can derive its own widths.
  function automatic int calc_offset_w(input int words_per_line);
    return 2 + $clog2(words_per_line);
  endfunction

  function automatic int calc_index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int calc_tag_w(input int num_lines, input int words_per_line);
    return 32 - calc_offset_w(words_per_line) - calc_index_w(num_lines);
  endfunction

  localparam int OFFSET_W = calc_offset_w(DEF_WORDS_PER_LINE);
  localparam int INDEX_W  = calc_index_w(DEF_NUM_LINES);
  localparam int TAG_W    = calc_tag_w(DEF_NUM_LINES, DEF_WORDS_PER_LINE);
  localparam int LINE_W   = 32 * DEF_WORDS_PER_LINE;

  // Extract 'width' bits of a byte address starting at bit 'lsb'.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb,
                                             input int width);
    logic [31:0] mask;
    mask = (32'h1 << width) - 32'h1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/mips_icache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: one write port,
// combinational read by index, valid bits cleared asynchronously on reset.
module mips_icache_line_store #(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 25,
  parameter int LINE_W    = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [INDEX_W-1:0] windex,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wdata,
  input  logic [INDEX_W-1:0] rindex,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rdata
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[windex] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid qualifies them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[windex]  <= wtag;
      data_q[windex] <= wdata;
    end
  end

  // Combinational read of the addressed line.
  always_comb begin
    rvalid = valid_q[rindex];
    rtag   = tag_q[rindex];
    rdata  = data_q[rindex];
  end

endmodule

// File: rtl/mips_icache.sv
// Direct-mapped read-only instruction cache. Hits return the word in the
// same cycle; a miss stalls the core and fetches one full line.
module mips_icache
  import mips_cache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         proc_read,
  input  logic [31:0]                                  proc_addr,
  output logic [31:0]                                  proc_rdata,
  output logic                                         proc_stall,
  output logic                                         mem_read,
  output logic [32-$clog2(4*WORDS_PER_LINE)-1:0]       mem_addr,
  input  logic [32*WORDS_PER_LINE-1:0]                 mem_rdata,
  input  logic                                         mem_ready
);

  localparam int OFF_W  = calc_offset_w(WORDS_PER_LINE);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = calc_index_w(NUM_LINES);
  localparam int TG_W   = calc_tag_w(NUM_LINES, WORDS_PER_LINE);
  localparam int LN_W   = 32 * WORDS_PER_LINE;
  localparam int MA_W   = 32 - OFF_W;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_sel;
  logic [IDX_W-1:0]  index;
  logic [TG_W-1:0]   tag;
  logic              line_valid;
  logic [TG_W-1:0]   line_tag;
  logic [LN_W-1:0]   line_data;
  logic [IDX_W-1:0]  fill_index;
  logic [TG_W-1:0]   fill_tag;
  logic              fill_we;
  logic              miss_start;
  logic              hit;

  assign word_sel   = WORD_W'(addr_field(proc_addr, 2, WORD_W));
  assign index      = IDX_W'(addr_field(proc_addr, OFF_W, IDX_W));
  assign tag        = TG_W'(addr_field(proc_addr, OFF_W + IDX_W, TG_W));

  // The fill target comes from the registered line address, so an address
  // change while stalled cannot redirect an in-flight fill.
  assign fill_index = mem_addr[IDX_W-1:0];
  assign fill_tag   = mem_addr[MA_W-1:IDX_W];

  assign hit = proc_read & line_valid & (line_tag == tag);

  mips_icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (IDX_W),
    .TAG_W     (TG_W),
    .LINE_W    (LN_W)
  ) u_line_store (
    .clk    (clk),
    .rst    (rst),
    .we     (fill_we),
    .windex (fill_index),
    .wtag   (fill_tag),
    .wdata  (mem_rdata),
    .rindex (index),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs; mem_read depends on state only.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = 32'h0;
    mem_read   = 1'b0;
    fill_we    = 1'b0;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (proc_read) begin
          if (hit) begin
            proc_rdata = line_data[{word_sel, 5'd0} +: 32];
          end else begin
            proc_stall = 1'b1;
            miss_start = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        mem_read   = 1'b1;
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line address captured when a miss is detected, held through the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (miss_start) begin
      mem_addr <= MA_W'(addr_field(proc_addr, OFF_W, MA_W));
    end
  end

endmodule

// File: tb/tb_mips_icache.sv
// Self-checking bench for mips_icache with a behavioural cache model.
module tb_mips_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  bit          mdl_valid [8];
  logic [24:0] mdl_tag   [8];

  mips_icache dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  // Backing instruction memory, indexed by word address.
  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    if (waddr < 32'd16) return waddr + 32'd1;
    return (waddr * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] laddr);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(laddr * 4 + w);
    return l;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 16) % 8);
  endfunction

  function automatic logic [24:0] tag_of(input logic [31:0] a);
    return 25'(a / 128);
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    return mdl_valid[idx_of(a)] && (mdl_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch; a miss is served by memory after 'lat' wait cycles.
  task automatic access(input logic [31:0] a, input int lat, input string nm);
    int stalls;
    logic [27:0] exp_ma;
    proc_read = 1'b1;
    proc_addr = a;
    mem_ready = 1'b0;
    #2;
    if (mdl_hit(a)) begin
      n_cmp++;
      if (proc_stall !== 1'b0 || proc_rdata !== mem_word(a / 4) || mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL %s hit @%h: stall=%b rdata=%h mem_read=%b, required stall=0 rdata=%h mem_read=0",
                 nm, a, proc_stall, proc_rdata, mem_read, mem_word(a / 4));
      end
      tick();
      return;
    end
    exp_ma = 28'(a / 16);
    n_cmp++;
    if (proc_stall !== 1'b1 || proc_rdata !== 32'h0 || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL %s miss-detect @%h: stall=%b rdata=%h mem_read=%b, required 1/0/0",
               nm, a, proc_stall, proc_rdata, mem_read);
    end
    stalls = 1;
    tick();
    for (int i = 0; i < lat; i++) begin
      n_cmp++;
      if (mem_read !== 1'b1 || mem_addr !== exp_ma || proc_stall !== 1'b1) begin
        n_err++;
        $display("FAIL %s fill-wait @%h: mem_read=%b mem_addr=%h stall=%b, required 1/%h/1",
                 nm, a, mem_read, mem_addr, proc_stall, exp_ma);
      end
      stalls++;
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = mem_line(a / 16);
    #1;
    n_cmp++;
    if (mem_read !== 1'b1 || mem_addr !== exp_ma || proc_stall !== 1'b1) begin
      n_err++;
      $display("FAIL %s fill-ready @%h: mem_read=%b mem_addr=%h stall=%b, required 1/%h/1",
               nm, a, mem_read, mem_addr, proc_stall, exp_ma);
    end
    stalls++;
    tick();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    mdl_valid[idx_of(a)] = 1'b1;
    mdl_tag[idx_of(a)]   = tag_of(a);
    #1;
    n_cmp++;
    if (proc_stall !== 1'b0 || proc_rdata !== mem_word(a / 4) || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL %s post-fill @%h: stall=%b rdata=%h mem_read=%b, required 0/%h/0",
               nm, a, proc_stall, proc_rdata, mem_read, mem_word(a / 4));
    end
    n_cmp++;
    if (stalls != 2 + lat) begin
      n_err++;
      $display("FAIL %s penalty @%h: stalled %0d cycles, required %0d", nm, a, stalls, 2 + lat);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    proc_read = 1'b0;
    proc_addr = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) mdl_valid[i] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || mem_addr !== 28'h0 || proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset: mem_read=%b mem_addr=%h stall=%b rdata=%h, required all 0",
               mem_read, mem_addr, proc_stall, proc_rdata);
    end
    proc_read = 1'b1;
    #1;
    n_cmp++;
    if (proc_stall !== 1'b1 || proc_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_read: stall=%b rdata=%h, required 1/0", proc_stall, proc_rdata);
    end
    proc_read = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    access(32'h0, 3, "cold_miss");
  endtask

  task automatic test_same_line();
    access(32'h4, 0, "same_line");
    access(32'h8, 0, "same_line");
    access(32'hC, 0, "same_line");
  endtask

  task automatic test_conflict();
    access(32'h80, 1, "conflict");
    access(32'h0, 0, "conflict");
  endtask

  task automatic test_boundary();
    access(32'hC, 0, "boundary");
    access(32'h10, 2, "boundary");
    access(32'h0, 0, "boundary");
    access(32'h70, 0, "wrap");
    access(32'h74, 0, "wrap");
    access(32'h4, 0, "wrap");
  endtask

  task automatic test_idle_spurious();
    proc_read = 1'b0;
    proc_addr = 32'h10;
    mem_ready = 1'b1;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #2;
    n_cmp++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h0 || mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL idle: stall=%b rdata=%h mem_read=%b, required 0/0/0",
               proc_stall, proc_rdata, mem_read);
    end
    tick();
    n_cmp++;
    if (mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL idle_state: mem_read=%b, required 0", mem_read);
    end
    mem_ready = 1'b0;
    access(32'h10, 0, "idle_nowrite");
    access(32'h14, 0, "idle_nowrite");
  endtask

  task automatic test_back_to_back();
    access(32'h50, 0, "b2b");
    access(32'h64, 0, "b2b");
    access(32'h58, 0, "b2b");
  endtask

  task automatic test_reset_mid_fill();
    proc_read = 1'b1;
    proc_addr = 32'h40;
    #2;
    tick();
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL rst_fill_enter: mem_read=%b, required 1", mem_read);
    end
    mem_ready = 1'b1;
    mem_rdata = mem_line(32'h4);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin
      n_err++;
      $display("FAIL rst_fill_drop: mem_read=%b mem_addr=%h, required 0/0", mem_read, mem_addr);
    end
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) mdl_valid[i] = 1'b0;
    access(32'h40, 1, "rst_refill");
    access(32'h0, 0, "rst_cleared");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      access(a, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line();
    test_conflict();
    test_boundary();
    test_idle_spurious();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
